// File: rtl/mem_copy_pkg.sv
// Shared types for mem_copy_engine: FSM state encoding.
package mem_copy_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    READ  = ST_READ,
    WRITE = ST_WRITE,
    DONE  = ST_DONE
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Word-at-a-time memory copy engine: READ/WRITE ping-pong on one shared address port.
// Optional FILL_MODE_EN build adds a constant-fill mode (1 cycle/word, no reads).
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
`ifdef FILL_MODE_EN
  input  logic         FillMode,
  input  logic [W-1:0] FillValue,
`endif
  output logic         Busy,
  output logic         Done,
  output logic [A-1:0] DataAddress,
  output logic [W-1:0] DataIn,
  output logic         MemWrite,
  input  logic [W-1:0] DataOut
);

  state_t         state, nxt;
  logic [A-1:0]   src_ptr, dst_ptr, cnt;
  logic [W-1:0]   data_q;
  logic           fill_q;
  logic           fill_start;
  logic [W-1:0]   wr_data;

`ifdef FILL_MODE_EN
  logic [W-1:0] fill_val_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (state == IDLE && Start) begin
      fill_q     <= FillMode;
      fill_val_q <= FillValue;
    end
  end

  assign fill_start = FillMode;
  assign wr_data    = fill_q ? fill_val_q : data_q;
`else
  assign fill_q     = 1'b0;
  assign fill_start = 1'b0;
  assign wr_data    = data_q;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= nxt;
  end

  // Pointers wrap naturally at A bits; no overlap correction, copy is strictly ascending.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      cnt     <= '0;
      data_q  <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          src_ptr <= SrcAddr;
          dst_ptr <= DstAddr;
          cnt     <= Len;
        end
        READ:  data_q <= DataOut;
        WRITE: begin
          src_ptr <= src_ptr + 1'b1;
          dst_ptr <= dst_ptr + 1'b1;
          cnt     <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    nxt         = state;
    Busy        = 1'b0;
    Done        = 1'b0;
    MemWrite    = 1'b0;
    DataAddress = '0;
    DataIn      = '0;
    case (state)
      IDLE: if (Start) begin
        if (Len == '0)      nxt = DONE;
        else if (fill_start) nxt = WRITE;
        else                 nxt = READ;
      end
      READ: begin
        Busy        = 1'b1;
        DataAddress = src_ptr;
        nxt         = WRITE;
      end
      WRITE: begin
        Busy        = 1'b1;
        MemWrite    = 1'b1;
        DataAddress = dst_ptr;
        DataIn      = wr_data;
        // cnt==1 means this write is the last one
        if (cnt == {{(A-1){1'b0}}, 1'b1}) nxt = DONE;
        else if (fill_q)                  nxt = WRITE;
        else                              nxt = READ;
      end
      DONE: begin
        Done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench for mem_copy_engine against a behavioural 256x8 memory with combinational read.
// Build with FILL_MODE_EN defined to also exercise fill mode.
module tb_mem_copy_engine;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic [7:0] SrcAddr = '0, DstAddr = '0, Len = '0;
  logic       Busy, Done, MemWrite;
  logic [7:0] DataAddress, DataIn, DataOut;
`ifdef FILL_MODE_EN
  logic       FillMode = 1'b0;
  logic [7:0] FillValue = '0;
`endif

  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];
  int         wr_cnt = 0;
  int         n_vec = 0, n_bad = 0;

  always #5 Clk = ~Clk;

  mem_copy_engine #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start),
    .SrcAddr(SrcAddr), .DstAddr(DstAddr), .Len(Len),
`ifdef FILL_MODE_EN
    .FillMode(FillMode), .FillValue(FillValue),
`endif
    .Busy(Busy), .Done(Done), .DataAddress(DataAddress),
    .DataIn(DataIn), .MemWrite(MemWrite), .DataOut(DataOut)
  );

  assign DataOut = mem[DataAddress];

  always @(posedge Clk) begin
    if (MemWrite) begin
      mem[DataAddress] <= DataIn;
      wr_cnt <= wr_cnt + 1;
    end
  end

  typedef struct {
    logic [7:0] src, dst, len;
    int         exp_cyc;
    int         exp_wr;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic init_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hC3;
    mem[10] = 8'd11; mem[11] = 8'd22; mem[12] = 8'd33; mem[13] = 8'd44;
    mem[254] = 8'd1; mem[255] = 8'd2; mem[0] = 8'd3;
  endtask

  // Independent reference: snapshot memory, then apply a forward word-by-word copy.
  task automatic ref_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l);
    logic [7:0] sp, dp;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem[i];
    sp = s; dp = d;
    for (int i = 0; i < int'(l); i++) begin
      ref_mem[dp] = ref_mem[sp];
      sp = sp + 8'd1; dp = dp + 8'd1;
    end
  endtask

  function automatic int mem_diffs();
    int n = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  // Called at a negedge. Returns the cycle (posedges after Start) at which Done was seen,
  // -1 on timeout, -2 when aborted by an injected reset.
  task automatic run_xfer(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                          input logic fm, input logic [7:0] fv,
                          input int inj_k, input int rst_k, output int done_at);
    int busy_bad;
    busy_bad = 0;
    done_at  = -1;
    wr_cnt   = 0;
    SrcAddr = s; DstAddr = d; Len = l;
`ifdef FILL_MODE_EN
    FillMode = fm; FillValue = fv;
`else
    if (fm) $display("note: fill request %0h ignored in copy-only build", fv);
`endif
    Start = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      Start = (k == inj_k);
      if (k == inj_k) begin
        SrcAddr = 8'd50; DstAddr = 8'd200; Len = 8'd2;
      end
      if (k == rst_k) begin
        Reset = 1'b0;
        #1;
        done_at = -2;
        break;
      end
      if (Done) begin
        if (Busy) busy_bad++;
        done_at = k;
        break;
      end
      if (!Busy) busy_bad++;
    end
    Start = 1'b0;
    chk("busy_window", busy_bad, 0);
  endtask

  int got;
  int extra_done;

  initial begin
    vecs[0] = '{src: 8'd10,  dst: 8'd100, len: 8'd4, exp_cyc: 9,  exp_wr: 4};
    vecs[1] = '{src: 8'd5,   dst: 8'd40,  len: 8'd0, exp_cyc: 1,  exp_wr: 0};
    vecs[2] = '{src: 8'd254, dst: 8'd0,   len: 8'd3, exp_cyc: 7,  exp_wr: 3};
    vecs[3] = '{src: 8'd30,  dst: 8'd31,  len: 8'd3, exp_cyc: 7,  exp_wr: 3};
    vecs[4] = '{src: 8'd200, dst: 8'd250, len: 8'd8, exp_cyc: 17, exp_wr: 8};

    // Reset state
    #12;
    chk("rst_busy", int'(Busy), 0);
    chk("rst_done", int'(Done), 0);
    chk("rst_memwrite", int'(MemWrite), 0);
    chk("rst_addr", int'(DataAddress), 0);
    chk("rst_datain", int'(DataIn), 0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < 5; i++) begin
      init_mem();
      ref_copy(vecs[i].src, vecs[i].dst, vecs[i].len);
      run_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, 1'b0, 8'h00, 0, 0, got);
      chk($sformatf("v%0d_done_cycle", i), got, vecs[i].exp_cyc);
      chk($sformatf("v%0d_writes", i), wr_cnt, vecs[i].exp_wr);
      chk($sformatf("v%0d_mem_diffs", i), mem_diffs(), 0);
      if (i == 0) begin
        chk("v0_mem100", int'(mem[100]), 11);
        chk("v0_mem103", int'(mem[103]), 44);
      end
      if (i == 1) chk("v1_mem40", int'(mem[40]), int'(8'd40 ^ 8'hC3));
      if (i == 2) begin
        chk("v2_mem0", int'(mem[0]), 1);
        chk("v2_mem1", int'(mem[1]), 2);
        chk("v2_mem2", int'(mem[2]), 1);
      end
      @(negedge Clk);
      chk($sformatf("v%0d_idle_after", i), int'(Done | Busy), 0);
    end

    // Start pulsed mid-transfer must be ignored
    init_mem();
    ref_copy(8'd10, 8'd110, 8'd4);
    run_xfer(8'd10, 8'd110, 8'd4, 1'b0, 8'h00, 3, 0, got);
    chk("ignore_done_cycle", got, 9);
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      if (Done || Busy) extra_done++;
    end
    chk("ignore_no_second", extra_done, 0);
    chk("ignore_writes", wr_cnt, 4);
    chk("ignore_mem_diffs", mem_diffs(), 0);

    // Reset during the second WRITE
    init_mem();
    run_xfer(8'd10, 8'd100, 8'd4, 1'b0, 8'h00, 0, 4, got);
    chk("abort_flag", got, -2);
    chk("abort_memwrite", int'(MemWrite), 0);
    chk("abort_addr", int'(DataAddress), 0);
    chk("abort_datain", int'(DataIn), 0);
    chk("abort_busy", int'(Busy), 0);
    @(negedge Clk);
    chk("abort_writes_1to2", int'(wr_cnt >= 1 && wr_cnt <= 2), 1);
    chk("abort_mem100", int'(mem[100]), 11);
    chk("abort_mem102", int'(mem[102]), int'(8'd102 ^ 8'hC3));
    chk("abort_mem103", int'(mem[103]), int'(8'd103 ^ 8'hC3));
    Reset = 1'b1;
    @(negedge Clk);
    init_mem();
    ref_copy(8'd10, 8'd100, 8'd4);
    run_xfer(8'd10, 8'd100, 8'd4, 1'b0, 8'h00, 0, 0, got);
    chk("post_abort_done", got, 9);
    chk("post_abort_mem_diffs", mem_diffs(), 0);

`ifdef FILL_MODE_EN
    @(negedge Clk);
    init_mem();
    run_xfer(8'd10, 8'd20, 8'd3, 1'b1, 8'hA5, 0, 0, got);
    chk("fill_done_cycle", got, 4);
    chk("fill_writes", wr_cnt, 3);
    chk("fill_mem20", int'(mem[20]), 8'hA5);
    chk("fill_mem22", int'(mem[22]), 8'hA5);
    chk("fill_mem23", int'(mem[23]), int'(8'd23 ^ 8'hC3));
    FillMode = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_copy_engine.md
MEM_COPY_ENGINE -- requirements
Module: mem_copy_engine

Interface
REQ-001 SHALL have parameter W, default 8: data width, matching the data memory word.
REQ-002 SHALL have parameter A, default 8: address width, for a 2**A-deep memory.
REQ-003 SHALL have port Clk, input, 1: single clock; all state changes on posedge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port Start, input, 1: request to begin a transfer, sampled in IDLE only.
REQ-006 SHALL have port SrcAddr, input, A: first source address, captured on an accepted Start.
REQ-007 SHALL have port DstAddr, input, A: first destination address, captured on an accepted Start.
REQ-008 SHALL have port Len, input, A: word count, 0..2**A-1, captured on an accepted Start.
REQ-009 SHALL have port Busy, output, 1: high from the cycle after an accepted Start until Done.
REQ-010 SHALL have port Done, output, 1: one-cycle completion pulse.
REQ-011 SHALL have port DataAddress, output, A: memory address pointer, shared by read and write.
REQ-012 SHALL have port DataIn, output, W: write data to memory.
REQ-013 SHALL have port MemWrite, output, 1: memory write enable.
REQ-014 SHALL have port DataOut, input, W: combinational memory read data for DataAddress.

Function
REQ-015 SHALL implement states IDLE, READ, WRITE, DONE.
REQ-016 IDLE: Start=1 SHALL capture SrcAddr/DstAddr/Len; go to READ if Len!=0, else DONE.
REQ-017 READ: SHALL drive DataAddress=src pointer with MemWrite=0, latch DataOut at posedge, then go to WRITE.
REQ-018 WRITE: SHALL drive DataAddress=dst pointer, DataIn=latched word, MemWrite=1; at posedge SHALL increment both pointers and decrement the remaining count.
REQ-019 WRITE: SHALL go to READ if remaining count after decrement !=0, else DONE.
REQ-020 DONE: SHALL assert Done for exactly one cycle with Busy=0, then return to IDLE.
REQ-021 Throughput SHALL be 2 cycles per word; Len=N>0 SHALL produce Done 2N+1 cycles after the Start edge.
REQ-022 Pointers SHALL wrap modulo 2**A (255+1 -> 0).
REQ-023 Copy SHALL be strictly ascending; overlapping regions SHALL give forward-copy semantics (no overlap correction).
REQ-024 Start while not IDLE SHALL be ignored, with no effect on the transfer in progress.
REQ-025 In IDLE and DONE: MemWrite=0, DataAddress=0, DataIn=0.
REQ-026 MemWrite SHALL be high only in WRITE.

Reset
REQ-027 Reset low SHALL immediately force IDLE, Busy=0, Done=0, MemWrite=0, DataAddress=0, DataIn=0, and clear pointers, count and latched data.
REQ-028 Reset mid-transfer SHALL abort with no further writes; words already written stay in memory.

Configuration
REQ-029 With FILL_MODE_EN defined: SHALL add inputs FillMode (1) and FillValue (W), captured on an accepted Start.
REQ-030 With FILL_MODE_EN and FillMode=1: SHALL skip READ, write FillValue at each dst address in WRITE (1 cycle/word, Done N+1 cycles after Start), and ignore SrcAddr.
REQ-031 Without FILL_MODE_EN: the ports SHALL be absent and behaviour SHALL be copy-only.

Structure
REQ-032 Package mem_copy_pkg SHALL hold the state enum type and the state encoding constants.
REQ-033 There SHALL be no sub-module; the block is a single FSM plus datapath registers, verified against an instance of the existing data memory.

Verification
REQ-034 Preload mem[10..13]=11,22,33,44; Start with Src=10, Dst=100, Len=4 -> mem[100..103]=11,22,33,44; Done pulses 9 cycles after Start; exactly 4 MemWrite cycles.
REQ-035 Start with Len=0 -> Done the next cycle; no MemWrite; memory unchanged.
REQ-036 Src=254, Dst=0, Len=3, mem[254]=1, mem[255]=2, mem[0]=3 -> mem[0..2]=1,2,1 (source wraps, overlap gives forward-copy result).
REQ-037 Pulse Start with Src=50 at cycle 3 of a Src=10, Len=4 transfer -> second request ignored; only the first transfer completes.
REQ-038 Assert Reset during the 2nd WRITE of a Len=4 copy -> outputs 0 immediately; only 1-2 destination words are written; the next Start runs normally.
REQ-039 With FILL_MODE_EN: FillMode=1, FillValue=8'hA5, Dst=20, Len=3 -> mem[20..22]=A5; Done 4 cycles after Start.
